// File: rtl/bin2bcd_serial_if.sv
// Request/result bundle between a requester and bin2bcd_serial.
// The blank flags exist only when BIN2BCD_BLANK_EN is defined.
interface bin2bcd_serial_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] bin_in;
  logic             busy;
  logic             done;
  logic [3:0]       bcd_hundreds;
  logic [3:0]       bcd_tens;
  logic [3:0]       bcd_units;
`ifdef BIN2BCD_BLANK_EN
  logic             blank_hundreds;
  logic             blank_tens;

  modport master (
    output start, bin_in,
    input  busy, done, bcd_hundreds, bcd_tens, bcd_units, blank_hundreds, blank_tens
  );
  modport slave (
    input  start, bin_in,
    output busy, done, bcd_hundreds, bcd_tens, bcd_units, blank_hundreds, blank_tens
  );
`else
  modport master (
    output start, bin_in,
    input  busy, done, bcd_hundreds, bcd_tens, bcd_units
  );
  modport slave (
    input  start, bin_in,
    output busy, done, bcd_hundreds, bcd_tens, bcd_units
  );
`endif
endinterface

// File: rtl/bin2bcd_serial.sv
// Iterative double-dabble binary-to-BCD converter, one bit per clock, three digits.
// Define BIN2BCD_BLANK_EN to add registered leading-zero blank flags.
module bin2bcd_serial #(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst_n,
  bin2bcd_serial_if.slave  bus
);
  localparam int CNT_W  = $clog2(WIDTH + 1);
  localparam int WORK_W = 12 + WIDTH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  function automatic logic [3:0] dabble(input logic [3:0] digit);
    logic [3:0] res;
    if (digit >= 4'd5) res = digit + 4'd3;
    else               res = digit;
    return res;
  endfunction

  state_e            state_r;
  state_e            state_nxt_s;
  // scratch BCD digits sit above the binary shift register so one shift moves both
  logic [WORK_W-1:0] work_r;
  logic [WORK_W-1:0] work_adj_s;
  logic [WORK_W-1:0] work_nxt_s;
  logic [CNT_W-1:0]  cnt_r;
  logic              last_shift_s;
  logic              busy_r;
  logic              done_r;
  logic [3:0]        hundreds_r;
  logic [3:0]        tens_r;
  logic [3:0]        units_r;

  assign last_shift_s = (cnt_r == CNT_W'(WIDTH - 1));

  // Add-3 correction on each scratch digit followed by the one-bit left shift
  always_comb begin
    work_adj_s                  = work_r;
    work_adj_s[WORK_W-1 -: 4]   = dabble(work_r[WORK_W-1 -: 4]);
    work_adj_s[WIDTH+7 -: 4]    = dabble(work_r[WIDTH+7 -: 4]);
    work_adj_s[WIDTH+3 -: 4]    = dabble(work_r[WIDTH+3 -: 4]);
    work_nxt_s                  = work_adj_s << 1'b1;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= S_IDLE;
    else        state_r <= state_nxt_s;
  end

  // FSM next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (bus.start) state_nxt_s = S_SHIFT;
        else           state_nxt_s = S_IDLE;
      end
      S_SHIFT: begin
        if (last_shift_s) state_nxt_s = S_DONE;
        else              state_nxt_s = S_SHIFT;
      end
      S_DONE:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Status flags registered from the next state so they align with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_nxt_s != S_IDLE);
      done_r <= (state_nxt_s == S_DONE);
    end
  end

  // Conversion datapath; result digits update only on the edge entering DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_r     <= '0;
      cnt_r      <= '0;
      hundreds_r <= 4'd0;
      tens_r     <= 4'd0;
      units_r    <= 4'd0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (bus.start) begin
            work_r <= {12'd0, bus.bin_in};
            cnt_r  <= '0;
          end
        end
        S_SHIFT: begin
          work_r <= work_nxt_s;
          cnt_r  <= cnt_r + CNT_W'(1);
          if (last_shift_s) begin
            hundreds_r <= work_nxt_s[WORK_W-1 -: 4];
            tens_r     <= work_nxt_s[WIDTH+7 -: 4];
            units_r    <= work_nxt_s[WIDTH+3 -: 4];
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef BIN2BCD_BLANK_EN
  logic blank_h_r;
  logic blank_t_r;

  // Blank flags track the digits on the same edge; reset reads as all-blank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_h_r <= 1'b1;
      blank_t_r <= 1'b1;
    end else if ((state_r == S_SHIFT) && last_shift_s) begin
      blank_h_r <= (work_nxt_s[WORK_W-1 -: 4] == 4'd0);
      blank_t_r <= (work_nxt_s[WORK_W-1 -: 4] == 4'd0) && (work_nxt_s[WIDTH+7 -: 4] == 4'd0);
    end
  end

  assign bus.blank_hundreds = blank_h_r;
  assign bus.blank_tens     = blank_t_r;
`endif

  assign bus.busy         = busy_r;
  assign bus.done         = done_r;
  assign bus.bcd_hundreds = hundreds_r;
  assign bus.bcd_tens     = tens_r;
  assign bus.bcd_units    = units_r;

endmodule

// File: tb/tb_bin2bcd_serial.sv
// Scoreboard bench for bin2bcd_serial: an 8-bit and a 9-bit instance share clock and reset.
// Expected digits come from decimal arithmetic on the requested value.
module tb_bin2bcd_serial;
  typedef struct {
    int val;
    int acc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t q8[$];
  exp_t q9[$];
  int   lv[2] = '{0, 0};
  int   prev_done[2] = '{0, 0};

  bin2bcd_serial_if #(.WIDTH(8)) if8 ();
  bin2bcd_serial_if #(.WIDTH(9)) if9 ();

  bin2bcd_serial #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
  bin2bcd_serial #(.WIDTH(9)) dut9 (.clk(clk), .rst_n(rst_n), .bus(if9));

  logic bh8, bt8, bh9, bt9;
`ifdef BIN2BCD_BLANK_EN
  assign bh8 = if8.blank_hundreds;
  assign bt8 = if8.blank_tens;
  assign bh9 = if9.blank_hundreds;
  assign bt9 = if9.blank_tens;
`else
  assign bh8 = 1'b0;
  assign bt8 = 1'b0;
  assign bh9 = 1'b0;
  assign bt9 = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void chk(input string name, input int sel, input int act, input int exp_v);
    vectors++;
    if (act != exp_v) begin
      miscompares++;
      $display("FAIL %s w%0d: got %0d, expected %0d (cycle %0d)", name, (sel == 0) ? 8 : 9, act, exp_v, cyc);
    end
  endfunction

  function automatic logic busy_of(input int sel);
    return (sel == 0) ? if8.busy : if9.busy;
  endfunction

  task automatic mon_check(input int sel, input logic d, input logic b, input logic [3:0] h,
                           input logic [3:0] t, input logic [3:0] u, input logic bh, input logic bt);
    exp_t e;
    int   depth;
    int   w;
    int   v;
    w = (sel == 0) ? 8 : 9;
    if (prev_done[sel] != 0) chk("busy_after_done", sel, int'(b), 0);
    if (d) begin
      chk("busy_with_done", sel, int'(b), 1);
      chk("done_one_cycle", sel, prev_done[sel], 0);
      depth = (sel == 0) ? q8.size() : q9.size();
      chk("queue_depth_at_done", sel, depth, 1);
      if (depth > 0) begin
        if (sel == 0) e = q8.pop_front();
        else          e = q9.pop_front();
        chk("done_latency", sel, cyc - e.acc, w);
        lv[sel] = e.val;
      end
    end
    v = lv[sel];
    chk("hundreds", sel, int'(h), v / 100);
    chk("tens", sel, int'(t), (v / 10) % 10);
    chk("units", sel, int'(u), v % 10);
`ifdef BIN2BCD_BLANK_EN
    chk("blank_hundreds", sel, int'(bh), int'(v < 100));
    chk("blank_tens", sel, int'(bt), int'(v < 10));
`endif
    prev_done[sel] = d ? 1 : 0;
  endtask

  // Monitor: samples both instances just after each rising edge
  always @(posedge clk) begin
    #1;
    mon_check(0, if8.done, if8.busy, if8.bcd_hundreds, if8.bcd_tens, if8.bcd_units, bh8, bt8);
    mon_check(1, if9.done, if9.busy, if9.bcd_hundreds, if9.bcd_tens, if9.bcd_units, bh9, bt9);
  end

  task automatic conv(input int sel, input int val, input int hold, output int acc);
    int   n;
    exp_t e;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy_of(sel) && n < 64);
    chk("wait_idle", sel, int'(busy_of(sel)), 0);
    e.val = val;
    e.acc = cyc + 1;
    acc   = e.acc;
    if (sel == 0) begin
      if8.start  = 1'b1;
      if8.bin_in = 8'(val);
      q8.push_back(e);
    end else begin
      if9.start  = 1'b1;
      if9.bin_in = 9'(val);
      q9.push_back(e);
    end
    @(negedge clk);
    if (hold > 0) begin
      if (sel == 0) if8.bin_in = 8'd200;
      else          if9.bin_in = 9'd200;
      repeat (hold) @(negedge clk);
    end
    if (sel == 0) if8.start = 1'b0;
    else          if9.start = 1'b0;
  endtask

  task automatic check_reset_state();
    chk("rst_busy8", 0, int'(if8.busy), 0);
    chk("rst_done8", 0, int'(if8.done), 0);
    chk("rst_digits8", 0, int'({if8.bcd_hundreds, if8.bcd_tens, if8.bcd_units}), 0);
    chk("rst_busy9", 1, int'(if9.busy), 0);
    chk("rst_done9", 1, int'(if9.done), 0);
    chk("rst_digits9", 1, int'({if9.bcd_hundreds, if9.bcd_tens, if9.bcd_units}), 0);
`ifdef BIN2BCD_BLANK_EN
    chk("rst_blanks8", 0, int'({bh8, bt8}), 3);
    chk("rst_blanks9", 1, int'({bh9, bt9}), 3);
`endif
  endtask

  initial begin
    int a1, a2, sel, val, n;
    rst_n      = 1'b0;
    if8.start  = 1'b0;
    if8.bin_in = 8'd0;
    if9.start  = 1'b0;
    if9.bin_in = 9'd0;
    repeat (2) @(negedge clk);
    check_reset_state();
    rst_n = 1'b1;

    conv(0, 255, 0, a1);
    conv(0, 0, 0, a1);
    conv(0, 100, 0, a2);
    chk("accept_spacing8", 0, a2 - a1, 10);
    conv(0, 37, 3, a1);
    conv(0, 7, 0, a1);
    conv(0, 50, 0, a1);
    conv(0, 0, 0, a1);

    // abort a conversion with a one-cycle reset pulse
    conv(0, 255, 0, a1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    q8.delete();
    q9.delete();
    lv[0] = 0;
    lv[1] = 0;
    #1;
    check_reset_state();
    @(negedge clk);
    rst_n = 1'b1;
    conv(0, 42, 0, a1);

    conv(1, 511, 0, a1);
    conv(1, 99, 0, a2);
    chk("accept_spacing9", 1, a2 - a1, 11);

    for (int i = 0; i < 30; i++) begin
      sel = int'($urandom_range(0, 1));
      val = (sel == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 511));
      conv(sel, val, int'($urandom_range(0, 2)), a1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    n = 0;
    while ((q8.size() + q9.size()) > 0 && n < 64) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("drain8", 0, q8.size(), 0);
    chk("drain9", 1, q9.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
